// File: rtl/mem_pkg.sv
// Shared types and default build constants for the block memory controller.
package mem_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_BLOCK_W = 128;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BUSY = 2'd1,
    ST_RD_BUSY = 2'd2,
    ST_RD_RESP = 2'd3
  } mem_state_t;

  // max(1, clog2(lat)) so a single-cycle build still has a one-bit counter
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Block storage: synchronous write, combinational read, contents survive reset.
module mem_array #(
  parameter int DEPTH   = 256,
  parameter int BLOCK_W = 128,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [BLOCK_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [BLOCK_W-1:0] rdata_o
);

  logic [BLOCK_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_ctrl.sv
// Cache-facing block memory controller: fixed-latency write-back and refill
// with a ready/valid response, write given priority over a pending read.
//
// state      | meaning
// IDLE       | ready for a write-back; a pending refill is accepted if no write
// WR_BUSY    | counting down; block is committed to the array at count 0
// RD_BUSY    | counting down toward the refill response
// RD_RESP    | refill block presented until the cache takes it
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_en_mem,
  input  logic               write_en_mem,
  input  logic               valid_cache,
  input  logic               ready_cache,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [BLOCK_W-1:0] wdata,
  output logic               ready_mem,
  output logic               valid_mem,
  output logic [BLOCK_W-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLOCK_W-1:0] wdata_q, wdata_d;
  logic               arr_we;
  logic [BLOCK_W-1:0] arr_rdata;
  logic [IDX_W-1:0]   idx;

  // Upper address bits alias away by truncation
  assign idx = addr_q[IDX_W-1:0];
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W];

  mem_array #(
    .DEPTH   (DEPTH),
    .BLOCK_W (BLOCK_W)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (idx),
    .wdata_i (wdata_q),
    .raddr_i (idx),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    arr_we    = 1'b0;
    ready_mem = 1'b0;
    valid_mem = 1'b0;
    rdata     = '0;
    unique case (state_q)
      ST_IDLE: begin
        ready_mem = 1'b1;
        // Write wins; a held read_en_mem is picked up on the next IDLE cycle
        if (valid_cache && write_en_mem) begin
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
          state_d = ST_WR_BUSY;
        end else if (read_en_mem) begin
          addr_d  = addr;
          cnt_d   = CNT_LOAD;
          state_d = ST_RD_BUSY;
        end
      end
      ST_WR_BUSY: begin
        if (cnt_q == '0) begin
          arr_we  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_BUSY: begin
        if (cnt_q == '0) state_d = ST_RD_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RD_RESP: begin
        valid_mem = 1'b1;
        rdata     = arr_rdata;
        if (ready_cache) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: LATENCY=4 instance for the main scenarios and
// a LATENCY=1 instance for the single-cycle build.
module tb_mem_ctrl;

  localparam int AW = 32;
  localparam int BW = 128;
  localparam int DP = 256;

  localparam logic [BW-1:0] D_A5   = {16{8'hA5}};
  localparam logic [BW-1:0] D_77   = {16{8'h77}};
  localparam logic [BW-1:0] D_11   = {16{8'h11}};
  localparam logic [BW-1:0] D_5A   = {16{8'h5A}};
  localparam logic [BW-1:0] D_1234 = 128'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance
  logic          rst = 1'b1;
  logic          rd_en = 1'b0, wr_en = 1'b0, vc = 1'b0, rc = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [BW-1:0] wdata = '0;
  logic          rm, vm;
  logic [BW-1:0] rdata;

  // LATENCY=1 instance
  logic          rst_l = 1'b1;
  logic          rd_en_l = 1'b0, wr_en_l = 1'b0, vc_l = 1'b0, rc_l = 1'b0;
  logic [AW-1:0] addr_l = '0;
  logic [BW-1:0] wdata_l = '0;
  logic          rm_l, vm_l;
  logic [BW-1:0] rdata_l;

  int nvec = 0;
  int nerr = 0;

  mem_ctrl #(.ADDR_W(AW), .BLOCK_W(BW), .DEPTH(DP), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .read_en_mem(rd_en), .write_en_mem(wr_en),
    .valid_cache(vc), .ready_cache(rc), .addr(addr), .wdata(wdata),
    .ready_mem(rm), .valid_mem(vm), .rdata(rdata)
  );

  mem_ctrl #(.ADDR_W(AW), .BLOCK_W(BW), .DEPTH(DP), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst_l), .read_en_mem(rd_en_l), .write_en_mem(wr_en_l),
    .valid_cache(vc_l), .ready_cache(rc_l), .addr(addr_l), .wdata(wdata_l),
    .ready_mem(rm_l), .valid_mem(vm_l), .rdata(rdata_l)
  );

  // Full write on the LATENCY=4 instance; ends on the negedge back in IDLE.
  task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
    vc = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    vc = 1'b0; wr_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++; if (rm !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b expected 1", rm); end
    nvec++; if (vm !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", vm); end
    nvec++; if (rdata !== '0) begin nerr++; $display("FAIL reset_rdata: got %0h expected 0", rdata); end
    nvec++; if (rm_l !== 1'b1) begin nerr++; $display("FAIL reset_ready_l1: got %b expected 1", rm_l); end
    rst = 1'b0; rst_l = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, low;
    vc = 1'b1; wr_en = 1'b1; addr = 32'h10; wdata = D_A5; rc = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin vc = 1'b0; wr_en = 1'b0; end
      if (rm === 1'b1) begin lat = i; break; end
    end
    nvec++; if (lat != 5) begin nerr++; $display("FAIL wr_ready_latency: got %0d expected 5", lat); end
    rd_en = 1'b1; addr = 32'h10;
    lat = 0; low = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rm === 1'b0) low++;
      if (vm === 1'b1) begin lat = i; break; end
    end
    rd_en = 1'b0;
    nvec++; if (lat != 5) begin nerr++; $display("FAIL rd_valid_latency: got %0d expected 5", lat); end
    nvec++; if (rdata !== D_A5) begin nerr++; $display("FAIL rd_data: got %0h expected %0h", rdata, D_A5); end
    @(negedge clk);
    if (rm === 1'b0) low++;
    nvec++; if (low != 5) begin nerr++; $display("FAIL rd_ready_low_cycles: got %0d expected 5", low); end
    nvec++; if (vm !== 1'b0) begin nerr++; $display("FAIL rd_valid_after_hs: got %b expected 0", vm); end
    nvec++; if (rdata !== '0) begin nerr++; $display("FAIL rd_rdata_after_hs: got %0h expected 0", rdata); end
  endtask

  task automatic test_write_priority();
    int ready_at, lat;
    rd_en = 1'b1; vc = 1'b1; wr_en = 1'b1; addr = 32'h20; wdata = D_1234; rc = 1'b1;
    ready_at = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin vc = 1'b0; wr_en = 1'b0; end
      if (rm === 1'b1 && ready_at == 0) ready_at = i;
      if (vm === 1'b1) begin lat = i; break; end
    end
    rd_en = 1'b0;
    nvec++; if (ready_at != 5) begin nerr++; $display("FAIL raw_idle_gap: got %0d expected 5", ready_at); end
    nvec++; if (lat != 10) begin nerr++; $display("FAIL raw_valid_at: got %0d expected 10", lat); end
    nvec++; if (rdata !== D_1234) begin nerr++; $display("FAIL raw_data: got %0h expected %0h", rdata, D_1234); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    rc = 1'b0; rd_en = 1'b1; addr = 32'h10;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vm === 1'b1) begin lat = i; break; end
    end
    nvec++; if (lat != 5) begin nerr++; $display("FAIL bp_valid_at: got %0d expected 5", lat); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      nvec++; if (vm !== 1'b1) begin nerr++; $display("FAIL bp_valid_hold%0d: got %b expected 1", k, vm); end
      nvec++; if (rdata !== D_A5) begin nerr++; $display("FAIL bp_rdata_hold%0d: got %0h expected %0h", k, rdata, D_A5); end
    end
    rc = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    nvec++; if (vm !== 1'b0) begin nerr++; $display("FAIL bp_exit_valid: got %b expected 0", vm); end
    nvec++; if (rm !== 1'b1) begin nerr++; $display("FAIL bp_exit_ready: got %b expected 1", rm); end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    do_write(32'h30, D_77);
    vc = 1'b1; wr_en = 1'b1; addr = 32'h30; wdata = 128'hFF;
    @(negedge clk);
    vc = 1'b0; wr_en = 1'b0;
    nvec++; if (rm !== 1'b0) begin nerr++; $display("FAIL rstw_busy1: got %b expected 0", rm); end
    @(negedge clk);
    nvec++; if (rm !== 1'b0) begin nerr++; $display("FAIL rstw_busy2: got %b expected 0", rm); end
    rst = 1'b1;
    #1;
    nvec++; if (rm !== 1'b1) begin nerr++; $display("FAIL rstw_async_idle: got %b expected 1", rm); end
    @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b1; addr = 32'h30; rc = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vm === 1'b1) begin lat = i; break; end
    end
    rd_en = 1'b0;
    nvec++; if (lat != 5) begin nerr++; $display("FAIL rstw_read_at: got %0d expected 5", lat); end
    nvec++; if (rdata !== D_77) begin nerr++; $display("FAIL rstw_old_data: got %0h expected %0h", rdata, D_77); end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    int lat;
    do_write(32'h40, D_11);
    vc = 1'b1; wr_en = 1'b0; wdata = 128'h2222;
    @(negedge clk);
    nvec++; if (rm !== 1'b1) begin nerr++; $display("FAIL ign_valid_only: got %b expected 1", rm); end
    vc = 1'b0; wr_en = 1'b1; wdata = 128'h3333;
    @(negedge clk);
    nvec++; if (rm !== 1'b1) begin nerr++; $display("FAIL ign_wen_only: got %b expected 1", rm); end
    wr_en = 1'b0;
    rd_en = 1'b1; addr = 32'h40; rc = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vm === 1'b1) begin lat = i; break; end
    end
    rd_en = 1'b0;
    nvec++; if (rdata !== D_11) begin nerr++; $display("FAIL ign_data: got %0h expected %0h", rdata, D_11); end
    @(negedge clk);
  endtask

  task automatic test_alias();
    int lat;
    do_write(32'(DP + 5), D_5A);
    rd_en = 1'b1; addr = 32'h5; rc = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 2) begin
        nvec++; if (rdata !== '0) begin nerr++; $display("FAIL alias_busy_rdata: got %0h expected 0", rdata); end
      end
      if (vm === 1'b1) begin lat = i; break; end
    end
    rd_en = 1'b0;
    nvec++; if (lat != 5) begin nerr++; $display("FAIL alias_valid_at: got %0d expected 5", lat); end
    nvec++; if (rdata !== D_5A) begin nerr++; $display("FAIL alias_data: got %0h expected %0h", rdata, D_5A); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_lat1();
    vc_l = 1'b1; wr_en_l = 1'b1; addr_l = 32'h1; wdata_l = 128'hAAA;
    @(negedge clk);
    vc_l = 1'b0; wr_en_l = 1'b0;
    nvec++; if (rm_l !== 1'b0) begin nerr++; $display("FAIL l1_wr_busy: got %b expected 0", rm_l); end
    @(negedge clk);
    nvec++; if (rm_l !== 1'b1) begin nerr++; $display("FAIL l1_wr_done: got %b expected 1", rm_l); end
    vc_l = 1'b1; wr_en_l = 1'b1; addr_l = 32'h2; wdata_l = 128'hBBB;
    @(negedge clk);
    vc_l = 1'b0; wr_en_l = 1'b0;
    @(negedge clk);
    rd_en_l = 1'b1; addr_l = 32'h1; rc_l = 1'b1;
    @(negedge clk);
    nvec++; if (vm_l !== 1'b0) begin nerr++; $display("FAIL l1_rd1_busy: got %b expected 0", vm_l); end
    @(negedge clk);
    nvec++; if (vm_l !== 1'b1) begin nerr++; $display("FAIL l1_rd1_valid: got %b expected 1", vm_l); end
    nvec++; if (rdata_l !== 128'hAAA) begin nerr++; $display("FAIL l1_rd1_data: got %0h expected aaa", rdata_l); end
    addr_l = 32'h2;
    @(negedge clk);
    nvec++; if (rm_l !== 1'b1) begin nerr++; $display("FAIL l1_idle_between: got %b expected 1", rm_l); end
    @(negedge clk);
    nvec++; if (vm_l !== 1'b0) begin nerr++; $display("FAIL l1_rd2_busy: got %b expected 0", vm_l); end
    @(negedge clk);
    nvec++; if (vm_l !== 1'b1) begin nerr++; $display("FAIL l1_rd2_valid: got %b expected 1", vm_l); end
    nvec++; if (rdata_l !== 128'hBBB) begin nerr++; $display("FAIL l1_rd2_data: got %0h expected bbb", rdata_l); end
    rd_en_l = 1'b0;
    @(negedge clk);
    nvec++; if (rm_l !== 1'b1) begin nerr++; $display("FAIL l1_final_idle: got %b expected 1", rm_l); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_priority();
    test_backpressure();
    test_reset_mid_write();
    test_ignore();
    test_alias();
    test_back_to_back_lat1();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the block address.
REQ-002 SHALL have parameter BLOCK_W, default 128, width of one cache block.
REQ-003 SHALL have parameter DEPTH, default 256, number of stored blocks (power of two).
REQ-004 SHALL have parameter LATENCY, default 4, busy cycles per access (>=1).
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 read_en_mem  input  1  cache requests a block refill (level, held until the response handshake).
REQ-008 write_en_mem  input  1  cache write-back enable.
REQ-009 valid_cache  input  1  cache presents a write-back block.
REQ-010 ready_cache  input  1  cache can accept refill data.
REQ-011 addr  input  ADDR_W  block address; index = addr[$clog2(DEPTH)-1:0].
REQ-012 wdata  input  BLOCK_W  write-back block.
REQ-013 ready_mem  output  1  memory idle; accepts a write-back.
REQ-014 valid_mem  output  1  rdata holds a valid refill block.
REQ-015 rdata  output  BLOCK_W  refill block.

Function
REQ-016 SHALL implement the FSM IDLE, WR_BUSY, RD_BUSY, RD_RESP.
REQ-017 IDLE: ready_mem=1, valid_mem=0.
REQ-018 Write accept: in IDLE with valid_cache && write_en_mem && ready_mem, SHALL latch addr/wdata, load counter LATENCY-1, and go to WR_BUSY.
REQ-019 Read accept: in IDLE with read_en_mem and no write accept, SHALL latch addr, load counter LATENCY-1, and go to RD_BUSY.
REQ-020 Simultaneous write and read in IDLE: write SHALL win; read_en_mem remains pending and is accepted on the first IDLE cycle after the write (read-after-write ordering).
REQ-021 WR_BUSY / RD_BUSY: ready_mem=0, valid_mem=0; counter decrements each cycle.
REQ-022 At counter==0 in WR_BUSY: SHALL write the latched block to the array and return to IDLE.
REQ-023 At counter==0 in RD_BUSY: SHALL go to RD_RESP.
REQ-024 RD_RESP: valid_mem=1, ready_mem=0, rdata=array[latched index]; rdata stable while waiting.
REQ-025 RD_RESP SHALL hold until valid_mem && ready_cache, then go to IDLE.
REQ-026 Latency: write accept to ready_mem=1 is LATENCY+1 cycles; read accept to valid_mem=1 is LATENCY+1 cycles.
REQ-027 LATENCY=1: counter loads 0, so the busy state lasts exactly one cycle.
REQ-028 rdata SHALL be 0 outside RD_RESP.
REQ-029 Addresses beyond DEPTH alias by truncation; no error is raised.
REQ-030 Counter width SHALL be max(1,$clog2(LATENCY)).
REQ-031 write_en_mem without valid_cache, or valid_cache without write_en_mem, SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE, counter=0, ready_mem=1, valid_mem=0, rdata=0, and clear latched addr/wdata.
REQ-033 Reset in WR_BUSY SHALL drop the uncommitted write; array contents are otherwise unaffected by reset.
REQ-034 Reset in RD_BUSY or RD_RESP SHALL abort the response with no handshake completed.

Structure
REQ-035 Package mem_pkg SHALL hold the state enum mem_state_t and the default parameter constants.
REQ-036 Storage SHALL be a sub-module mem_array: DEPTH x BLOCK_W, synchronous write, combinational read, no reset.

Verification (LATENCY=4)
REQ-037 Write-back then refill: write addr=0x10, data=0xA5..A5; then read 0x10 -> ready_mem low 5 cycles; valid_mem high 5 cycles after read accept with rdata=0xA5..A5.
REQ-038 Simultaneous valid_cache&&write_en_mem and read_en_mem, same addr 0x20, new data 0x1234 -> write first; read returns 0x1234 on valid_mem.
REQ-039 Backpressure: ready_cache=0 for 3 cycles in RD_RESP -> valid_mem and rdata stable; exit the cycle ready_cache=1.
REQ-040 Reset asserted on the 2nd WR_BUSY cycle of a write of 0xFF to 0x30 -> IDLE next; a later read of 0x30 returns the previous contents.
REQ-041 LATENCY=1 build: read accept -> valid_mem high 2 cycles later; back-to-back reads accepted without stall beyond latency.
REQ-042 addr=DEPTH+5 write, then read of addr 5 -> returns the same data (aliasing).
